imem_stream_loader: RTL and testbench
=====================================

Name: imem_stream_loader

Overview:
- Writer side of the instruction memory: assembles a byte stream from a host/boot interface into 32-bit instruction words.
- Issues single-cycle word writes into the instruction memory's storage array at word-aligned byte addresses 0, 4, 8, ….
- The fetch path reads the same array via addressin[31:2].
- Runs before the processor is released. Loads exactly the requested number of words, then pulses done.

Parameters:
- DEPTH, 512, instruction memory capacity in words; largest legal load length.
- BIG_ENDIAN, 1, 1: first byte of each word goes to [31:24]; 0: first byte goes to [7:0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- length_words  input  10  number of words to load; sampled on the start cycle.
- abort  input  1  cancel the load in progress and return to IDLE.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  word write strobe, one cycle.
- mem_addr  output  32  byte address of the write; always a multiple of 4.
- mem_wdata  output  32  assembled word.
- busy  output  1  high in LOAD and WRITE.
- done  output  1  one-cycle pulse when a load completes.
- error  output  1  sticky; set when length_words exceeds DEPTH; cleared by the next accepted start or by rst.
- words_loaded  output  10  count of words written in the current/last load.

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0: byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_loaded. Byte index 0, shift register 0.
- FSM states:
  - IDLE: byte_ready=0. On start:
    - If length_words==0: go to DONE, no writes.
    - Else if length_words>DEPTH: set error, go to DONE, no writes.
    - Else: latch length, clear error, words_loaded and address, go to LOAD.
  - LOAD: byte_ready=1.
    - A byte is accepted on a rising edge with byte_valid&&byte_ready.
    - Accepted bytes are placed by byte index 0..3 per BIG_ENDIAN.
    - On accepting byte index 3: present the assembled word on mem_wdata, go to WRITE.
  - WRITE: exactly one cycle. mem_we=1, mem_addr=current address, byte_ready=0.
    - Next edge: address+=4, words_loaded+=1, byte index←0.
    - If words_loaded+1==latched length: go to DONE, else go to LOAD.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: mem_we asserts in the cycle immediately after the 4th byte of a word is accepted. Minimum 5 cycles per word.
- byte_valid with byte_ready=0 is ignored; the data is not consumed.
- A byte presented during WRITE must be held by the source; it is accepted in the next LOAD cycle.
- start while busy is ignored; the latched length is unchanged.
- abort (LOAD or WRITE) returns to IDLE on the next edge:
  - a pending WRITE is not performed;
  - the partial word is discarded;
  - done is not pulsed;
  - words_loaded retains words already written.
  - abort has priority over a simultaneous byte accept or a simultaneous WRITE.
- mem_addr never exceeds 4*(DEPTH-1). Address wrap is impossible by the length check.
- mem_wdata holds its last value when mem_we=0. mem_addr holds the address of the last write.
- rst asserted mid-load: immediate return to reset values. Already-written memory words are not this block's concern.

Test Plan:
- Reset values:
  - Stimulus: rst high for 2 cycles, then low.
  - Required: all outputs 0, state IDLE, byte_ready=0.
- Two-word big-endian load:
  - Stimulus: start, length=2; bytes 8C,01,00,04, 20,02,00,05 with continuous valid.
  - Required: mem_we at addr 0 with data 8C010004, then at addr 4 with data 20020005. done pulses one cycle after the second WRITE. words_loaded=2.
- Stalled source:
  - Stimulus: byte_valid toggled 1,0,0,1,… across the bytes of one word.
  - Required: only valid&&ready bytes are accepted; the word is assembled correctly. A byte held through WRITE is accepted on the first LOAD cycle with no duplication.
- Length boundaries:
  - length=0: done pulse next cycle, no mem_we, error=0.
  - length=513: error=1, done pulses, no mem_we.
  - length=512: last write at addr 0x7FC.
- Abort and restart:
  - Abort after 6 bytes of a 3-word load.
  - Required: one write only, at addr 0; no done; words_loaded=1; IDLE.
  - A new start then writes from addr 0 again.
- Little-endian and ignored start:
  - Stimulus: BIG_ENDIAN=0, bytes 04,00,01,8C; also pulse start mid-load.
  - Required: word 8C010004; the start pulse has no effect.

Source files
------------

// File: rtl/imem_stream_loader_if.sv
// Host/boot-side stream and instruction-memory write bus of the loader.
interface imem_stream_loader_if;
  logic        start;
  logic [9:0]  length_words;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [9:0]  words_loaded;

  // Host / boot controller side
  modport master (
    output start, length_words, abort, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_loaded
  );

  // Loader side
  modport slave (
    input  start, length_words, abort, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_loaded
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Instruction-memory writer: packs a byte stream into 32-bit words and
// writes them to word-aligned addresses 0, 4, 8, ... before core release.
module imem_stream_loader #(
  parameter int DEPTH      = 512,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  imem_stream_loader_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [10:0] DEPTH_W = 11'(DEPTH);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [9:0]  len_q, len_d;
  logic [9:0]  wl_q, wl_d;
  logic        err_q, err_d;
  logic [31:0] shift_nxt;

  // Insert one byte into the assembly register according to byte order.
  function automatic logic [31:0] place_byte(input logic [31:0] sr, input logic [7:0] b);
    if (BIG_ENDIAN)
      return {sr[23:0], b};
    else
      return {b, sr[31:8]};
  endfunction

  assign shift_nxt = place_byte(shift_q, bus.byte_in);

  // Next-state and datapath update; abort wins over accept and write.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wl_d    = wl_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          err_d = 1'b0;
          if (bus.length_words == 10'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, bus.length_words} > DEPTH_W) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            len_d   = bus.length_words;
            wl_d    = 10'd0;
            idx_d   = 2'd0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (bus.abort) begin
          idx_d   = 2'd0;
          state_d = S_IDLE;
        end else if (bus.byte_valid) begin
          shift_d = shift_nxt;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Word address follows the count of words already written.
            wdata_d = shift_nxt;
            addr_d  = {20'd0, wl_q, 2'b00};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (bus.abort) begin
          idx_d   = 2'd0;
          state_d = S_IDLE;
        end else begin
          wl_d    = wl_q + 10'd1;
          idx_d   = 2'd0;
          state_d = ((wl_q + 10'd1) == len_q) ? S_DONE : S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      shift_q <= 32'd0;
      wdata_q <= 32'd0;
      addr_q  <= 32'd0;
      len_q   <= 10'd0;
      wl_q    <= 10'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wl_q    <= wl_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready   = (state_q == S_LOAD);
  assign bus.mem_we       = (state_q == S_WRITE) && !bus.abort;
  assign bus.busy         = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.error        = err_q;
  assign bus.words_loaded = wl_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench for imem_stream_loader: big- and little-endian instances, scoreboard
// of expected memory writes checked as the loader issues them.
module tb_imem_stream_loader;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk;
  logic rst;
  logic sel_le;
  logic start_r;
  logic [9:0] len_r;
  logic abort_r;
  logic [7:0] bin_r;
  logic bvalid_r;

  int checks;
  int failures;
  int wr_cnt;
  int done_cnt;
  wr_t sb[$];
  logic [7:0] bq[$];

  imem_stream_loader_if ifb ();
  imem_stream_loader_if ifl ();

  imem_stream_loader #(.DEPTH(512), .BIG_ENDIAN(1'b1)) u_be (.clk(clk), .rst(rst), .bus(ifb));
  imem_stream_loader #(.DEPTH(512), .BIG_ENDIAN(1'b0)) u_le (.clk(clk), .rst(rst), .bus(ifl));

  assign ifb.start        = start_r & ~sel_le;
  assign ifb.length_words = len_r;
  assign ifb.abort        = abort_r & ~sel_le;
  assign ifb.byte_in      = bin_r;
  assign ifb.byte_valid   = bvalid_r & ~sel_le;
  assign ifl.start        = start_r & sel_le;
  assign ifl.length_words = len_r;
  assign ifl.abort        = abort_r & sel_le;
  assign ifl.byte_in      = bin_r;
  assign ifl.byte_valid   = bvalid_r & sel_le;

  logic        m_ready, m_we, m_busy, m_done, m_err;
  logic [31:0] m_addr, m_wdata;
  logic [9:0]  m_wl;
  assign m_ready = sel_le ? ifl.byte_ready   : ifb.byte_ready;
  assign m_we    = sel_le ? ifl.mem_we       : ifb.mem_we;
  assign m_busy  = sel_le ? ifl.busy         : ifb.busy;
  assign m_done  = sel_le ? ifl.done         : ifb.done;
  assign m_err   = sel_le ? ifl.error        : ifb.error;
  assign m_addr  = sel_le ? ifl.mem_addr     : ifb.mem_addr;
  assign m_wdata = sel_le ? ifl.mem_wdata    : ifb.mem_wdata;
  assign m_wl    = sel_le ? ifl.words_loaded : ifb.words_loaded;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitor: every mem_we must match the head of the scoreboard.
  always begin
    wr_t e;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (m_done) done_cnt++;
      if (m_we) begin
        wr_cnt++;
        chk("addr_align", {30'd0, m_addr[1:0]}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_we", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", m_addr, e.a);
          chk("wr_data", m_wdata, e.d);
        end
      end
    end
  end

  task automatic do_start(input logic [9:0] len);
    start_r = 1'b1;
    len_r   = len;
    @(negedge clk);
    start_r = 1'b0;
    #1;
  endtask

  // Stream bq out; stall=1 gives a 1,0,0 valid pattern, holding a byte once offered.
  task automatic send_bytes(input int stall);
    int i;
    int k;
    int cyc;
    i = 0; k = 0; cyc = 0;
    while (i < bq.size() && cyc < 5000) begin
      bin_r    = bq[i];
      bvalid_r = (stall == 0) ? 1'b1 : (k % 3 == 0);
      #1;
      if (bvalid_r && m_ready) begin
        i++;
        k++;
      end else if (!bvalid_r) begin
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    bvalid_r = 1'b0;
    if (cyc >= 5000) chk("send_timeout", 32'(i), 32'(bq.size()));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!m_done && n < 40);
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d, input bit be);
    sb.push_back('{a: a, d: d});
    if (be) begin
      bq.push_back(d[31:24]); bq.push_back(d[23:16]); bq.push_back(d[15:8]); bq.push_back(d[7:0]);
    end else begin
      bq.push_back(d[7:0]); bq.push_back(d[15:8]); bq.push_back(d[23:16]); bq.push_back(d[31:24]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    int d0;
    logic [31:0] rd;
    checks = 0; failures = 0; wr_cnt = 0; done_cnt = 0;
    rst = 1'b1; sel_le = 1'b0; start_r = 1'b0; len_r = 10'd0;
    abort_r = 1'b0; bin_r = 8'd0; bvalid_r = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, m_ready}, 32'd0);
    chk("rst_we", {31'd0, m_we}, 32'd0);
    chk("rst_addr", m_addr, 32'd0);
    chk("rst_wdata", m_wdata, 32'd0);
    chk("rst_busy", {31'd0, m_busy}, 32'd0);
    chk("rst_done", {31'd0, m_done}, 32'd0);
    chk("rst_error", {31'd0, m_err}, 32'd0);
    chk("rst_wl", {22'd0, m_wl}, 32'd0);
    @(negedge clk);

    // Two-word big-endian load with continuous valid
    bq.delete();
    push_word(32'h0, 32'h8C010004, 1'b1);
    push_word(32'h4, 32'h20020005, 1'b1);
    do_start(10'd2);
    chk("two_busy", {31'd0, m_busy}, 32'd1);
    send_bytes(0);
    wait_done(n);
    chk("two_done_lat", 32'(n), 32'd1);
    chk("two_wl", {22'd0, m_wl}, 32'd2);
    @(negedge clk); #1;
    chk("two_done_1cyc", {31'd0, m_done}, 32'd0);
    chk("two_sb_empty", 32'(sb.size()), 32'd0);

    // Stalled source across two words
    bq.delete();
    push_word(32'h0, 32'h11223344, 1'b1);
    push_word(32'h4, 32'h55667788, 1'b1);
    do_start(10'd2);
    send_bytes(1);
    wait_done(n);
    chk("stall_done_lat", 32'(n), 32'd1);
    chk("stall_wl", {22'd0, m_wl}, 32'd2);
    chk("stall_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);

    // length = 0
    w0 = wr_cnt;
    do_start(10'd0);
    chk("len0_done", {31'd0, m_done}, 32'd1);
    chk("len0_error", {31'd0, m_err}, 32'd0);
    @(negedge clk); #1;
    chk("len0_done_1cyc", {31'd0, m_done}, 32'd0);
    chk("len0_no_we", 32'(wr_cnt), 32'(w0));

    // length = 513
    do_start(10'd513);
    chk("len513_done", {31'd0, m_done}, 32'd1);
    chk("len513_error", {31'd0, m_err}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("len513_error_sticky", {31'd0, m_err}, 32'd1);
    chk("len513_no_we", 32'(wr_cnt), 32'(w0));

    // length = 512, full memory
    bq.delete();
    for (int w = 0; w < 512; w++) begin
      rd = $urandom;
      push_word(32'(w * 4), rd, 1'b1);
    end
    do_start(10'd512);
    chk("len512_error_clr", {31'd0, m_err}, 32'd0);
    send_bytes(0);
    wait_done(n);
    chk("len512_done_lat", 32'(n), 32'd1);
    chk("len512_wl", {22'd0, m_wl}, 32'd512);
    chk("len512_last_addr", m_addr, 32'h7FC);
    chk("len512_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);

    // Abort after 6 bytes of a 3-word load
    bq.delete();
    push_word(32'h0, 32'hA1B2C3D4, 1'b1);
    bq.push_back(8'hE5); bq.push_back(8'hF6);
    w0 = wr_cnt; d0 = done_cnt;
    do_start(10'd3);
    send_bytes(0);
    abort_r = 1'b1;
    @(negedge clk);
    abort_r = 1'b0;
    #1;
    chk("abort_idle", {31'd0, m_busy}, 32'd0);
    repeat (4) @(negedge clk);
    #3;
    chk("abort_writes", 32'(wr_cnt - w0), 32'd1);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_wl", {22'd0, m_wl}, 32'd1);
    chk("abort_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);

    // Restart after abort writes from address 0
    bq.delete();
    push_word(32'h0, 32'hCAFEF00D, 1'b1);
    do_start(10'd1);
    send_bytes(0);
    wait_done(n);
    chk("restart_done_lat", 32'(n), 32'd1);
    chk("restart_wl", {22'd0, m_wl}, 32'd1);
    chk("restart_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);

    // Little-endian instance, start pulsed mid-load
    sel_le = 1'b1;
    @(negedge clk);
    bq.delete();
    push_word(32'h0, 32'h8C010004, 1'b0);
    do_start(10'd2);
    send_bytes(0);
    @(negedge clk);
    do_start(10'd5);
    bq.delete();
    push_word(32'h4, 32'h12345678, 1'b0);
    send_bytes(0);
    wait_done(n);
    chk("le_done_lat", 32'(n), 32'd1);
    chk("le_wl", {22'd0, m_wl}, 32'd2);
    @(negedge clk);
    #3;
    chk("le_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
